// File: rtl/clock_reset_sequencer_pkg.sv
// Shared definitions for the clock/reset sequencer.
// Holds the state encoding (also exported on the debug state port), the parameter defaults
// shared by the RTL and the benches, and small helpers.
package clock_reset_sequencer_pkg;

    localparam int unsigned DefSettleCycles = 1024;
    localparam int unsigned DefStageGap     = 16;
    localparam int unsigned DefSlowDiv      = 8;
    localparam int unsigned DefLockFilter   = 4;

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StSettle   = 3'd1,
        StRelFast  = 3'd2,
        StRelSlow  = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } state_e;

    // States where the fast domain is out of reset and the slow-domain divider runs.
    function automatic logic is_active(state_e st);
        return (st == StRelFast) || (st == StRelSlow) || (st == StRun);
    endfunction

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// Control/status bundle of the clock/reset sequencer.
// master: the requester side (drives pll_lock, soft_reset, fault_clear).
// slave:  the sequencer (drives reset_fast, reset_slow, ce_slow, ready, fault, state).
interface clock_reset_sequencer_if;
    import clock_reset_sequencer_pkg::*;

    logic   pll_lock;
    logic   soft_reset;
    logic   fault_clear;
    logic   reset_fast;
    logic   reset_slow;
    logic   ce_slow;
    logic   ready;
    logic   fault;
    state_e state;

    modport master (
        output pll_lock, soft_reset, fault_clear,
        input  reset_fast, reset_slow, ce_slow, ready, fault, state
    );

    modport slave (
        input  pll_lock, soft_reset, fault_clear,
        output reset_fast, reset_slow, ce_slow, ready, fault, state
    );

endinterface

// File: rtl/clock_reset_sequencer_lock_filter.sv
// PLL lock qualifier: double-flop synchronizer followed by an agreement filter.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   pll_lock    - raw asynchronous PLL lock
//   lock_good   - filtered lock; flips only after LockFilter consecutive opposing samples
module clock_reset_sequencer_lock_filter #(
    parameter int unsigned LockFilter = clock_reset_sequencer_pkg::DefLockFilter
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_good
);
    localparam int unsigned CntW = $clog2(LockFilter) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LockFilter - 1);

    logic            sync1_q, sync2_q;
    logic            good_q, good_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count samples that disagree with the current verdict; any agreeing sample restarts the run.
    always_comb begin
        good_d = good_q;
        cnt_d  = '0;
        if (sync2_q != good_q) begin
            if (cnt_q == CntLast) begin
                good_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            good_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
            good_q  <= good_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lock_good = good_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Bring-up sequencer for the fast and slow clock domains behind the PLL.
// Waits for a filtered, settled lock, releases the fast then the slow domain reset, generates
// the slow-domain clock enable, supervises lock while running and services soft resets.
// Ports:
//   clk, rst_n - system clock (PLL output), asynchronous active-low reset
//   bus        - slave side: pll_lock/soft_reset/fault_clear in;
//                reset_fast/reset_slow/ce_slow/ready/fault/state out (all registered)
module clock_reset_sequencer
    import clock_reset_sequencer_pkg::*;
#(
    parameter int unsigned SettleCycles = DefSettleCycles,
    parameter int unsigned StageGap     = DefStageGap,
    parameter int unsigned SlowDiv      = DefSlowDiv,
    parameter int unsigned LockFilter   = DefLockFilter
) (
    input logic                     clk,
    input logic                     rst_n,
    clock_reset_sequencer_if.slave  bus
);
    localparam int unsigned CntW = cnt_width(SettleCycles, StageGap);
    localparam int unsigned DivW = $clog2(SlowDiv) + 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(StageGap - 1);
    localparam logic [DivW-1:0] DivLast    = DivW'(SlowDiv - 1);

    logic            lock_good;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            reset_fast_q, reset_fast_d;
    logic            reset_slow_q, reset_slow_d;
    logic            ce_q, ce_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;

    clock_reset_sequencer_lock_filter #(
        .LockFilter (LockFilter)
    ) u_lock_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (bus.pll_lock),
        .lock_good (lock_good)
    );

    // Lock loss outranks soft reset once the fast domain is released; in SETTLE both just
    // fall back to WAIT_LOCK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitLock: begin
                if (!bus.soft_reset && lock_good) state_d = StSettle;
            end
            StSettle: begin
                if (!lock_good || bus.soft_reset) state_d = StWaitLock;
                else if (cnt_q == SettleLast)     state_d = StRelFast;
            end
            StRelFast: begin
                if (!lock_good)               state_d = StFault;
                else if (bus.soft_reset)      state_d = StWaitLock;
                else if (cnt_q == GapLast)    state_d = StRelSlow;
            end
            StRelSlow: begin
                if (!lock_good)               state_d = StFault;
                else if (bus.soft_reset)      state_d = StWaitLock;
                else                          state_d = StRun;
            end
            StRun: begin
                if (!lock_good)               state_d = StFault;
                else if (bus.soft_reset)      state_d = StWaitLock;
            end
            StFault: begin
                if (bus.fault_clear)          state_d = StWaitLock;
            end
            default: state_d = StWaitLock;
        endcase
    end

    // Counters and outputs are computed from the next state so every output is a flop that
    // already reflects the state being entered.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StSettle || state_q == StRelFast) && state_d == state_q) begin
            cnt_d = cnt_q + CntW'(1);
        end

        div_d = '0;
        if (is_active(state_d) && is_active(state_q)) begin
            div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end

        ce_d         = is_active(state_d) && (div_d == DivLast);
        reset_fast_d = !is_active(state_d);
        reset_slow_d = !(state_d == StRelSlow || state_d == StRun);
        ready_d      = (state_d == StRun);
        fault_d      = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            div_q        <= '0;
            reset_fast_q <= 1'b1;
            reset_slow_q <= 1'b1;
            ce_q         <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            reset_fast_q <= reset_fast_d;
            reset_slow_q <= reset_slow_d;
            ce_q         <= ce_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.reset_fast = reset_fast_q;
    assign bus.reset_slow = reset_slow_q;
    assign bus.ce_slow    = ce_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench for clock_reset_sequencer: the stimulus process queues the expected output
// transitions (value and cycle); monitors compare whenever the observed outputs change and
// check the slow clock-enable cadence.
module tb_clock_reset_sequencer;
    import clock_reset_sequencer_pkg::*;

    localparam int unsigned Settle = 32;
    localparam int unsigned Gap    = 4;
    localparam int unsigned Div    = 4;
    localparam int unsigned Filt   = 4;
    // Cycles from driving pll_lock high (or releasing rst_n) to entering SETTLE.
    localparam int unsigned LockLat = 2 + Filt + 1;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  vec;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clock_reset_sequencer_if bus ();

    clock_reset_sequencer #(
        .SettleCycles (Settle),
        .StageGap     (Gap),
        .SlowDiv      (Div),
        .LockFilter   (Filt)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [6:0] mk(logic rf, logic rs, logic rdy, logic flt, state_e st);
        return {rf, rs, rdy, flt, st};
    endfunction

    function automatic logic [6:0] cur_vec();
        return {bus.reset_fast, bus.reset_slow, bus.ready, bus.fault, bus.state};
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endfunction

    function automatic void push(int unsigned c, logic [6:0] v, string tag);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tag = tag;
        expq.push_back(e);
    endfunction

    // Full bring-up from SETTLE entry at cycle base.
    function automatic void bringup(int unsigned base, string tag);
        push(base,                  mk(1'b1, 1'b1, 1'b0, 1'b0, StSettle),  {tag, "_settle"});
        push(base + Settle,         mk(1'b0, 1'b1, 1'b0, 1'b0, StRelFast), {tag, "_relfast"});
        push(base + Settle + Gap,   mk(1'b0, 1'b0, 1'b0, 1'b0, StRelSlow), {tag, "_relslow"});
        push(base + Settle + Gap + 1, mk(1'b0, 1'b0, 1'b1, 1'b0, StRun),   {tag, "_run"});
    endfunction

    task automatic drain(int limit);
        int n = 0;
        while (expq.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            chk({"drain_timeout_", expq[0].tag}, 32'(expq.size()), 32'd0);
            expq.delete();
        end
    endtask

    task automatic wait_cyc(int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Output-transition monitor.
    initial begin
        logic [6:0] prev;
        logic [6:0] v;
        exp_t e;
        prev = mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                v = cur_vec();
                if (v !== prev) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_change", 32'(v), 32'(prev));
                    end else begin
                        e = expq.pop_front();
                        chk({e.tag, "_vec"}, 32'(v), 32'(e.vec));
                        chk({e.tag, "_cyc"}, cyc, e.cyc);
                    end
                    prev = v;
                end
            end
        end
    end

    // ce_slow cadence monitor: first pulse SlowDiv-1 cycles after entering REL_FAST, then every
    // SlowDiv cycles, and never outside the released states.
    initial begin
        int unsigned start = 0;
        int unsigned last = 0;
        bit have_last = 1'b0;
        bit prev_act = 1'b0;
        bit act;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act = (bus.state == StRelFast) || (bus.state == StRelSlow) || (bus.state == StRun);
                if (act && !prev_act) begin
                    start = cyc;
                    have_last = 1'b0;
                end
                if (!act) begin
                    chk("ce_idle", 32'(bus.ce_slow), 32'd0);
                end else if (bus.ce_slow) begin
                    if (have_last) chk("ce_period", cyc - last, Div);
                    else           chk("ce_first", cyc - start, Div - 1);
                    last = cyc;
                    have_last = 1'b1;
                end
                prev_act = act;
            end
        end
    end

    initial begin
        int unsigned c;
        int n;
        bus.pll_lock = 1'b0;
        bus.soft_reset = 1'b0;
        bus.fault_clear = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(cur_vec()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock)));
        chk("reset_ce", 32'(bus.ce_slow), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Clean bring-up.
        c = cyc;
        bus.pll_lock = 1'b1;
        bringup(c + LockLat, "bringup");
        drain(80);

        // Ten strobes in any 40-cycle window of RUN.
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ce_slow) n++;
        end
        chk("ce_count", 32'(n), 32'd10);

        // Short glitch is filtered out.
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_state", 32'(bus.state), 32'(StRun));
        chk("glitch_fault", 32'(bus.fault), 32'd0);

        // Long drop faults; fault sticks with lock back.
        c = cyc;
        bus.pll_lock = 1'b0;
        push(c + 7, mk(1'b1, 1'b1, 1'b0, 1'b1, StFault), "lock_loss");
        repeat (6) @(negedge clk);
        bus.pll_lock = 1'b1;
        drain(20);
        repeat (100) @(negedge clk);
        chk("fault_sticky", 32'(bus.fault), 32'd1);
        chk("fault_resets", 32'({bus.reset_fast, bus.reset_slow}), 32'd3);

        // Fault clear re-runs the full sequence.
        c = cyc;
        bus.fault_clear = 1'b1;
        push(c + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "clear_wait");
        bringup(c + 2, "clear");
        @(negedge clk);
        bus.fault_clear = 1'b0;
        drain(60);

        // Soft reset in RUN.
        c = cyc;
        bus.soft_reset = 1'b1;
        push(c + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "soft_wait");
        bringup(c + 2, "soft");
        @(negedge clk);
        bus.soft_reset = 1'b0;
        drain(60);

        // Lock drop seen with settle count at 20, then a full settle after relock.
        c = cyc;
        bus.soft_reset = 1'b1;
        push(c + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "drop_soft");
        push(c + 2, mk(1'b1, 1'b1, 1'b0, 1'b0, StSettle), "drop_settle");
        push(c + 23, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "settle_drop");
        @(negedge clk);
        bus.soft_reset = 1'b0;
        wait_cyc(c + 16);
        bus.pll_lock = 1'b0;
        wait_cyc(c + 30);
        bus.pll_lock = 1'b1;
        bringup(c + 30 + LockLat, "relock");
        drain(100);

        // Soft reset in the same cycle as lock loss: fault wins.
        c = cyc;
        bus.pll_lock = 1'b0;
        push(c + 7, mk(1'b1, 1'b1, 1'b0, 1'b1, StFault), "soft_and_loss");
        wait_cyc(c + 6);
        bus.soft_reset = 1'b1;
        @(negedge clk);
        bus.soft_reset = 1'b0;
        bus.pll_lock = 1'b1;
        drain(20);
        repeat (20) @(negedge clk);
        c = cyc;
        bus.fault_clear = 1'b1;
        push(c + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "clear2_wait");
        bringup(c + 2, "clear2");
        @(negedge clk);
        bus.fault_clear = 1'b0;
        drain(60);

        // Asynchronous reset in REL_FAST.
        c = cyc;
        bus.soft_reset = 1'b1;
        push(c + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "arst_soft");
        push(c + 2, mk(1'b1, 1'b1, 1'b0, 1'b0, StSettle), "arst_settle");
        push(c + 34, mk(1'b0, 1'b1, 1'b0, 1'b0, StRelFast), "arst_relfast");
        @(negedge clk);
        bus.soft_reset = 1'b0;
        wait_cyc(c + 35);
        push(c + 36, mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock), "async_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vec", 32'(cur_vec()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, StWaitLock)));
        chk("async_rst_ce", 32'(bus.ce_slow), 32'd0);
        wait_cyc(c + 39);
        rst_n = 1'b1;
        bringup(c + 39 + LockLat, "post_rst");
        drain(100);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
